imem_boot_loader: RTL and testbench

//  Upstream stage of the single-cycle core: owns the instruction memory and fills it from a byte stream.

---
 rtl/mips_pkg.sv | 16 +
 rtl/boot_byte_packer.sv | 34 +++
 rtl/imem_boot_loader.sv | 143 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the boot loader and the single-cycle core.
package mips_pkg;

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        CSUM,
        RUN,
        ERR
    } boot_state_t;

    localparam logic [31:0] MIPS_NOP   = 32'h0000_0000;
    localparam int unsigned BOOT_CNT_W = 16;

endpackage

// File: rtl/boot_byte_packer.sv
// Packs accepted stream bytes little-endian into 32-bit words.
// word_valid pulses combinationally on the lane-3 accept with the complete word.
module boot_byte_packer (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  byte_in,
    input  logic        accept,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane_q;
    logic [23:0] sr_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lane_q <= 2'd0;
            sr_q   <= 24'd0;
        end else if (accept) begin
            lane_q <= lane_q + 2'd1;
            unique case (lane_q)
                2'd0:    sr_q[7:0]   <= byte_in;
                2'd1:    sr_q[15:8]  <= byte_in;
                2'd2:    sr_q[23:16] <= byte_in;
                default: ;
            endcase
        end
    end

    // Lane 3 bypasses the register so the word is written on the same edge.
    assign word_valid = accept && (lane_q == 2'd3);
    assign word       = {byte_in, sr_q};

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction memory filled from a length-prefixed byte stream; holds the core in reset until loaded.
// Optional trailing XOR checksum byte enabled by defining BOOT_CHECKSUM_EN.
module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [31:0] iaddr,
    output logic [31:0] instr,
    output logic        core_nrst,
    output logic        load_done,
    output logic        load_err
);

    localparam int unsigned AW = $clog2(DEPTH);

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t AfterData = CSUM;
`else
    localparam boot_state_t AfterData = RUN;
`endif

    boot_state_t           state_q, state_d;
    logic [BOOT_CNT_W-1:0] cnt_q, cnt_d;
    logic [BOOT_CNT_W-1:0] widx_q, widx_d;
    logic [BOOT_CNT_W-1:0] len;
    logic                  core_nrst_q;
    logic                  accept;
    logic                  pack_accept;
    logic                  word_valid;
    logic [31:0]           word;
    logic [31:0]           mem [DEPTH];

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    boot_byte_packer u_packer (
        .clk        (clk),
        .nrst       (nrst),
        .byte_in    (rx_data),
        .accept     (pack_accept),
        .word_valid (word_valid),
        .word       (word)
    );

    assign rx_ready = (state_q != RUN);
    assign accept   = rx_valid && rx_ready;
    assign len      = {rx_data, cnt_q[7:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        widx_d      = widx_q;
        pack_accept = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        unique case (state_q)
            LEN0: begin
                if (accept) begin
                    cnt_d[7:0] = rx_data;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    cnt_d[15:8] = rx_data;
                    if (len == '0) begin
                        state_d = AfterData;
                    end else if (len > BOOT_CNT_W'(DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                pack_accept = accept;
`ifdef BOOT_CHECKSUM_EN
                if (accept) csum_d = csum_q ^ rx_data;
`endif
                if (word_valid) begin
                    widx_d = widx_q + 1'b1;
                    if (widx_q == cnt_q - 1'b1) state_d = AfterData;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CSUM: begin
                if (accept) state_d = (rx_data == csum_q) ? RUN : ERR;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= LEN0;
            cnt_q       <= '0;
            widx_q      <= '0;
            core_nrst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            widx_q      <= widx_d;
            // Rises on the same edge that accepts the final byte.
            core_nrst_q <= (state_d == RUN);
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) csum_q <= 8'd0;
        else       csum_q <= csum_d;
    end
`endif

    // Contents are deliberately not reset; words >= N are masked on read.
    always_ff @(posedge clk) begin
        if (word_valid) mem[widx_q[AW-1:0]] <= word;
    end

    logic [AW-1:0] widx_rd;
    logic          rd_hit;
    logic          unused_addr_bits;

    assign widx_rd          = iaddr[AW+1:2];
    assign unused_addr_bits = ^iaddr[1:0];
    assign rd_hit           = load_done && (BOOT_CNT_W'(widx_rd) < cnt_q)
                              && (iaddr[31:AW+2] == '0);
    assign instr            = rd_hit ? mem[widx_rd] : MIPS_NOP;

    assign core_nrst = core_nrst_q;
    assign load_done = (state_q == RUN);
    assign load_err  = (state_q == ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader (DEPTH=64).
// Checksum scenarios are compiled in when BOOT_CHECKSUM_EN is defined.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        nrst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] iaddr;
    logic [31:0] instr;
    logic        core_nrst;
    logic        load_done;
    logic        load_err;

    int checks   = 0;
    int failures = 0;

    imem_boot_loader #(.DEPTH(64)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .iaddr     (iaddr),
        .instr     (instr),
        .core_nrst (core_nrst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    logic [7:0] stream2 [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h08, 8'h20,
                                 8'h2A, 8'h00, 8'h09, 8'h8C};
    // XOR of the 8 data bytes of stream2.
    localparam logic [7:0] Csum2 = 8'h13 ^ 8'h00 ^ 8'h08 ^ 8'h20 ^ 8'h2A ^ 8'h00 ^ 8'h09 ^ 8'h8C;

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        iaddr = a;
        #1;
        checks++;
        if (instr !== exp) begin
            failures++;
            $display("FAIL %s: instr=%h required %h", name, instr, exp);
        end
    endtask

    task automatic load_test2(input string tag);
        for (int i = 0; i < 9; i++) send_byte(stream2[i]);
        checks++;
        if (core_nrst !== 1'b0 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL %s_before_last: core_nrst=%b load_done=%b required 0 0",
                     tag, core_nrst, load_done);
        end
        send_byte(stream2[9]);
`ifdef BOOT_CHECKSUM_EN
        checks++;
        if (load_done !== 1'b0) begin
            failures++;
            $display("FAIL %s_wait_csum: load_done=%b required 0", tag, load_done);
        end
        send_byte(Csum2);
`endif
        rx_valid = 1'b0;
        checks++;
        if (core_nrst !== 1'b1 || load_done !== 1'b1 || rx_ready !== 1'b0 || load_err !== 1'b0)
        begin
            failures++;
            $display("FAIL %s_run: core_nrst=%b load_done=%b rx_ready=%b load_err=%b required 1 1 0 0",
                     tag, core_nrst, load_done, rx_ready, load_err);
        end
        read_check({tag, "_w0"}, 32'h0000_0000, 32'h2008_0013);
        read_check({tag, "_w1"}, 32'h0000_0004, 32'h8C09_002A);
        read_check({tag, "_w2_masked"}, 32'h0000_0008, 32'h0000_0000);
        read_check({tag, "_lowbits"}, 32'h0000_0007, 32'h8C09_002A);
        read_check({tag, "_high_addr"}, 32'h1000_0000, 32'h0000_0000);
    endtask

    task automatic test_reset();
        nrst     = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hAB;
        iaddr    = 32'h0;
        #75;
        checks++;
        if (rx_ready !== 1'b1 || core_nrst !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0)
        begin
            failures++;
            $display("FAIL reset_outputs: rx_ready=%b core_nrst=%b load_done=%b load_err=%b required 1 0 0 0",
                     rx_ready, core_nrst, load_done, load_err);
        end
        read_check("reset_instr0", 32'h0000_0000, 32'h0);
        read_check("reset_instr4", 32'h0000_0004, 32'h0);
        rx_valid = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load();
        load_test2("load");
    endtask

    task automatic test_length_error();
        do_reset();
        send_byte(8'h41);
        send_byte(8'h00);
        checks++;
        if (load_err !== 1'b1) begin
            failures++;
            $display("FAIL len_err_flag: load_err=%b required 1", load_err);
        end
        for (int i = 0; i < 500; i++) send_byte(8'(i));
        rx_valid = 1'b0;
        checks++;
        if (load_err !== 1'b1 || core_nrst !== 1'b0 || rx_ready !== 1'b1 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL len_err_hold: load_err=%b core_nrst=%b rx_ready=%b load_done=%b required 1 0 1 0",
                     load_err, core_nrst, rx_ready, load_done);
        end
        @(negedge clk);
        nrst = 1'b0;
        #2;
        checks++;
        if (load_err !== 1'b0) begin
            failures++;
            $display("FAIL len_err_clear: load_err=%b required 0", load_err);
        end
        nrst = 1'b1;
        // N == DEPTH is the largest legal length.
        do_reset();
        send_byte(8'h40);
        send_byte(8'h00);
        rx_valid = 1'b0;
        checks++;
        if (load_err !== 1'b0) begin
            failures++;
            $display("FAIL len_max_ok: load_err=%b required 0", load_err);
        end
    endtask

    task automatic test_stall_abort();
        do_reset();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        rx_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (load_done !== 1'b0 || core_nrst !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold: load_done=%b core_nrst=%b rx_ready=%b required 0 0 1",
                     load_done, core_nrst, rx_ready);
        end
        do_reset();
        load_test2("abort_reload");
    endtask

    task automatic test_zero_len();
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
        checks++;
        if (load_done !== 1'b0) begin
            failures++;
            $display("FAIL zero_wait_csum: load_done=%b required 0", load_done);
        end
        send_byte(8'h00);
`endif
        rx_valid = 1'b0;
        checks++;
        if (load_done !== 1'b1 || core_nrst !== 1'b1) begin
            failures++;
            $display("FAIL zero_run: load_done=%b core_nrst=%b required 1 1", load_done, core_nrst);
        end
        read_check("zero_instr0", 32'h0000_0000, 32'h0);
`ifdef BOOT_CHECKSUM_EN
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        rx_valid = 1'b0;
        checks++;
        if (load_err !== 1'b1 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL zero_bad_csum: load_err=%b load_done=%b required 1 0", load_err, load_done);
        end
`endif
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(stream2[i]);
        send_byte(Csum2 ^ 8'h01);
        rx_valid = 1'b0;
        checks++;
        if (load_err !== 1'b1 || core_nrst !== 1'b0 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL csum_mismatch: load_err=%b core_nrst=%b load_done=%b required 1 0 0",
                     load_err, core_nrst, load_done);
        end
        read_check("csum_err_instr0", 32'h0, 32'h0);
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_length_error();
        test_stall_abort();
        test_zero_len();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
